// File: rtl/rr_arb_two2four_if.sv
// rr_arb_two2four_if
//
// Groups the request/grant signals that pass between the four requesting
// agents and the round-robin arbiter that owns the shared 2-to-4 decoder.
//
// Signals:
//   req     [3:0]  request vector, req[i] held high by requester i until done
//   gnt     [3:0]  registered one-hot grant, zero when nobody owns the decoder
//   x0, x1         decoder select bits, equal to the owner index
//   busy           high while a grant is active
//   timeout        one-cycle pulse when a grant is forcibly revoked
//
// Modports:
//   master  the requester side: drives req, observes everything else
//   slave   the arbiter side: observes req, drives grant/select/status
interface rr_arb_two2four_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       x0;
    logic       x1;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  x0,
        input  x1,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output x0,
        output x1,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arb_two2four.sv
// rr_arb_two2four
//
// Four-way round-robin arbiter that turns the two2four 2-to-4 decoder into a
// single shared resource. One requester owns the decoder at a time; its
// index is presented on the decoder select (x1,x0) together with a
// registered one-hot grant. Every grant is followed by at least one IDLE
// cycle before the next one is issued.
//
// Parameters:
//   MAX_HOLD  maximum consecutive GRANT cycles for one owner (2..255);
//             only takes effect when ARB_TIMEOUT_EN is defined
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   bus_io  slave modport of rr_arb_two2four_if (req in; gnt, x0, x1,
//           busy, timeout out)
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Defined   - an 8-bit hold counter forcibly revokes a grant after
//               MAX_HOLD cycles and pulses timeout for one cycle.
//   Undefined - no counter is built, grants are unbounded, timeout is 0.
module rr_arb_two2four #(
    parameter int MAX_HOLD = 15
) (
    input  logic              clk,
    input  logic              rst,
    rr_arb_two2four_if.slave  bus_io
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [1:0] own_q,   own_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] gnt_q,   gnt_d;
    logic       busy_q,  busy_d;

    logic [1:0] pick;
    logic       found;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [7:0] holdCnt_q, holdCnt_d;
    logic       timeout_q, timeout_d;
`endif

    // Elaboration-time guard on the hold limit; the counter is only 8 bits
    // wide and a limit below 2 would revoke a grant before it was usable.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : gIllegalMaxHold
        $error("rr_arb_two2four: MAX_HOLD must be in 2..255");
    end

    // Round-robin scan: walk ptr, ptr+1, ptr+2, ptr+3 (2-bit arithmetic
    // wraps mod 4) and remember the first index whose request is high.
    // When nothing is requesting, pick is simply left at ptr and unused.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && bus_io.req[ptr_q + 2'(k)]) begin
                found = 1'b1;
                pick  = ptr_q + 2'(k);
            end
        end
    end

    // Next-state logic. From IDLE a pending request is granted on the next
    // edge and the pointer moves just past the winner so it becomes the
    // lowest priority next time. In GRANT only the owner's own request bit
    // matters; its release drops the grant and always passes through IDLE,
    // so a same-edge request from anyone else waits one more edge. The
    // select bits are only loaded on a new grant, which keeps the decoder
    // input stable for the whole grant and through the following IDLE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
`ifdef ARB_TIMEOUT_EN
        holdCnt_d = holdCnt_q;
        timeout_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus_io.req != 4'b0000) begin
                    state_d   = GRANT;
                    own_d     = pick;
                    sel_d     = pick;
                    gnt_d     = 4'b0001 << pick;
                    busy_d    = 1'b1;
                    ptr_d     = pick + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    holdCnt_d = 8'd0;
`endif
                end
            end

            GRANT: begin
                if (!bus_io.req[own_q]) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                // The counter reads HoldLast during the last permitted
                // grant cycle, so the grant is dropped on the edge that
                // would otherwise start cycle MAX_HOLD+1.
                else if (holdCnt_q == HoldLast) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end
                else begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
`endif
            end
        endcase
    end

    // State and output registers. Reset may arrive at any moment, including
    // mid-grant, and immediately clears every output and restores index 0
    // as the highest priority requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            own_q     <= 2'd0;
            sel_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            holdCnt_q <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Drive the interface straight from registers so every output is glitch
    // free toward the decoder and the requesters.
    assign bus_io.gnt  = gnt_q;
    assign bus_io.x0   = sel_q[0];
    assign bus_io.x1   = sel_q[1];
    assign bus_io.busy = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign bus_io.timeout = timeout_q;
`else
    assign bus_io.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb_two2four.sv
// tb_rr_arb_two2four
//
// Self-checking bench for rr_arb_two2four. A fixed table walks the arbiter
// through reset and a full rotation; short hand-written sequences cover
// sparse priority, hold-and-ignore, asynchronous reset mid-grant and the
// hold limit; a randomized phase then compares every cycle against a
// behavioural model that tracks the owner, the priority pointer and the
// number of cycles the current grant has lasted.
//
// Each compared value is packed as {gnt[3:0], x1, x0, busy, timeout}.
module tb_rr_arb_two2four;

    localparam int MaxHold = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
    } vec_t;

    logic clk;
    logic rst;

    rr_arb_two2four_if bus ();

    rr_arb_two2four #(
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state: owner index (-1 when nobody holds the grant),
    // priority pointer, last select value, cycles the grant has lasted and
    // the revocation pulse.
    int         mOwner;
    int         mPtr;
    int         mHeld;
    logic [1:0] mSel;
    logic       mPulse;

    vec_t rotTable [18];

    task automatic modelReset();
        mOwner = -1;
        mPtr   = 0;
        mHeld  = 0;
        mSel   = 2'b00;
        mPulse = 1'b0;
    endtask

    // One clock edge of the arbitration rules, given the request vector
    // sampled at that edge.
    task automatic modelStep(input logic [3:0] r);
        mPulse = 1'b0;
        if (mOwner < 0) begin
            if (r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (mPtr + k) % 4;
                    if (mOwner < 0 && r[idx]) mOwner = idx;
                end
                mPtr  = (mOwner + 1) % 4;
                mSel  = 2'(mOwner);
                mHeld = 1;
            end
        end else if (!r[mOwner]) begin
            mOwner = -1;
        end else if (TimeoutEn && mHeld == MaxHold) begin
            mOwner = -1;
            mPulse = 1'b1;
        end else begin
            mHeld = mHeld + 1;
        end
    endtask

    function automatic logic [7:0] modelVec();
        logic [3:0] g;
        g = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        return {g, mSel, (mOwner >= 0), mPulse};
    endfunction

    function automatic logic [7:0] expVec(input logic [3:0] g,
                                          input logic [1:0] s,
                                          input logic       to);
        return {g, s, (g != 4'b0000), to};
    endfunction

    function automatic logic [7:0] dutVec();
        return {bus.gnt, bus.x1, bus.x0, bus.busy, bus.timeout};
    endfunction

    // Drive a request vector just after an edge, let the next rising edge
    // sample it, advance the model and settle 1 ns past the edge.
    task automatic applyStimulus(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        if (rst) modelReset();
        else     modelStep(r);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expected);
        logic [7:0] actual;
        actual     = dutVec();
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got {gnt,x1,x0,busy,timeout}=%b, expected %b",
                     name, actual, expected);
        end
    endtask

    initial begin
        logic [3:0] r;

        // Reset with all four requesting, then a full rotation where each
        // owner keeps its grant for three cycles and drops its bit for one.
        rotTable[0]  = '{4'b1111, 4'b0001, 2'd0};
        rotTable[1]  = '{4'b1111, 4'b0001, 2'd0};
        rotTable[2]  = '{4'b1111, 4'b0001, 2'd0};
        rotTable[3]  = '{4'b1110, 4'b0000, 2'd0};
        rotTable[4]  = '{4'b1111, 4'b0010, 2'd1};
        rotTable[5]  = '{4'b1111, 4'b0010, 2'd1};
        rotTable[6]  = '{4'b1111, 4'b0010, 2'd1};
        rotTable[7]  = '{4'b1101, 4'b0000, 2'd1};
        rotTable[8]  = '{4'b1111, 4'b0100, 2'd2};
        rotTable[9]  = '{4'b1111, 4'b0100, 2'd2};
        rotTable[10] = '{4'b1111, 4'b0100, 2'd2};
        rotTable[11] = '{4'b1011, 4'b0000, 2'd2};
        rotTable[12] = '{4'b1111, 4'b1000, 2'd3};
        rotTable[13] = '{4'b1111, 4'b1000, 2'd3};
        rotTable[14] = '{4'b1111, 4'b1000, 2'd3};
        rotTable[15] = '{4'b0111, 4'b0000, 2'd3};
        rotTable[16] = '{4'b1111, 4'b0001, 2'd0};
        rotTable[17] = '{4'b0000, 4'b0000, 2'd0};

        rst     = 1'b1;
        bus.req = 4'b1111;
        modelReset();

        repeat (2) begin
            applyStimulus(4'b1111);
            checkOutput("reset_hold", 8'h00);
        end
        #2 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(rotTable[i].req);
            checkOutput($sformatf("rotation[%0d]", i),
                        expVec(rotTable[i].gnt, rotTable[i].sel, 1'b0));
        end

        // Sparse priority: after owner 2 the scan starts at 3, so 0 wins
        // over 1; the release edge itself grants nobody.
        applyStimulus(4'b0100);
        checkOutput("sparse_grant2", expVec(4'b0100, 2'd2, 1'b0));
        applyStimulus(4'b0011);
        checkOutput("sparse_release2", expVec(4'b0000, 2'd2, 1'b0));
        applyStimulus(4'b0011);
        checkOutput("sparse_grant0", expVec(4'b0001, 2'd0, 1'b0));
        applyStimulus(4'b0010);
        checkOutput("sparse_release0", expVec(4'b0000, 2'd0, 1'b0));
        applyStimulus(4'b0010);
        checkOutput("sparse_grant1", expVec(4'b0010, 2'd1, 1'b0));

        // Hold and ignore: new requests from 2 and 3 do not disturb owner 1.
        applyStimulus(4'b1110);
        checkOutput("hold_ignore_a", expVec(4'b0010, 2'd1, 1'b0));
        applyStimulus(4'b1110);
        checkOutput("hold_ignore_b", expVec(4'b0010, 2'd1, 1'b0));
        applyStimulus(4'b1100);
        checkOutput("hold_release1", expVec(4'b0000, 2'd1, 1'b0));
        applyStimulus(4'b1100);
        checkOutput("hold_next2", expVec(4'b0100, 2'd2, 1'b0));
        applyStimulus(4'b0000);
        checkOutput("hold_release2", expVec(4'b0000, 2'd2, 1'b0));

        // Asynchronous reset between edges while owner 3 holds the grant.
        applyStimulus(4'b1000);
        checkOutput("owner3_grant", expVec(4'b1000, 2'd3, 1'b0));
        applyStimulus(4'b1000);
        checkOutput("owner3_hold", expVec(4'b1000, 2'd3, 1'b0));
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_now", 8'h00);
        modelReset();
        rst = 1'b0;
        applyStimulus(4'b1111);
        checkOutput("restart_ptr0", expVec(4'b0001, 2'd0, 1'b0));
        applyStimulus(4'b0000);
        checkOutput("restart_release", expVec(4'b0000, 2'd0, 1'b0));

        // Hold limit: requester 0 never lets go. With the limit built the
        // grant lasts MaxHold cycles, is revoked with a timeout pulse, and
        // is re-issued on the following edge; without it the grant persists.
        for (int i = 0; i < MaxHold; i++) begin
            applyStimulus(4'b0001);
            checkOutput($sformatf("hold_limit_grant[%0d]", i),
                        expVec(4'b0001, 2'd0, 1'b0));
        end
        applyStimulus(4'b0001);
        checkOutput("hold_limit_revoke",
                    TimeoutEn ? expVec(4'b0000, 2'd0, 1'b1)
                              : expVec(4'b0001, 2'd0, 1'b0));
        applyStimulus(4'b0001);
        checkOutput("hold_limit_regrant", expVec(4'b0001, 2'd0, 1'b0));
        applyStimulus(4'b0000);
        checkOutput("hold_limit_release", expVec(4'b0000, 2'd0, 1'b0));

        // Randomized phase: request bits change on roughly a third of the
        // cycles so that grants last long enough to reach the hold limit.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) r = 4'($urandom);
            applyStimulus(r);
            checkOutput("random", modelVec());
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rr_arb_two2four.md
# rr_arb_two2four

Four-way round-robin arbiter that shares the `two2four` 2-to-4 decoder between four requesters. It accepts a request vector, grants exactly one requester at a time, and drives the decoder's 2-bit select (`x1`,`x0`) with the owner's index. It also provides a registered one-hot grant. It sits between the requesting agents and the decoder, making the decoder a single arbitrated resource.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive GRANT cycles for one owner. Used only when `ARB_TIMEOUT_EN` is defined. Legal range is 2..255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request vector; `req[i]` is held high by requester i until it is done.
- `gnt`  output  4  registered one-hot grant; all zero when no owner.
- `x0`  output  1  select bit 0 to the decoder, equal to owner index bit 0.
- `x1`  output  1  select bit 1 to the decoder, equal to owner index bit 1.
- `busy`  output  1  high while in GRANT.
- `timeout`  output  1  one-cycle pulse when a grant is revoked. Constant 0 without the macro.

## Operation
- State register has two states, IDLE and GRANT. Other internal state is `ptr[1:0]` (priority pointer) and `own[1:0]` (current owner).
- IDLE:
  - If `req` == 0, stay in IDLE.
  - Otherwise, scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). Select the first i with `req[i]`=1.
  - At the next edge: own←i, `gnt`←(1<<i), {`x1`,`x0`}←i, ptr←(i+1) mod 4, state←GRANT.
- GRANT:
  - While `req[own]`=1, hold `gnt`, `x1`/`x0` and `own` unchanged. Changes on other `req` bits are ignored.
  - When `req[own]`=0 at an edge: `gnt`←0, state←IDLE.
  - `x1`/`x0` keep the last owner index while IDLE. The decoder output is don't-care when `gnt`=0.
- Grants are never overlapped or switched directly. There is always at least one IDLE cycle between consecutive grants.
- Fairness: a requester that keeps `req` high is granted within 4 grant periods.
- Reset, asynchronous and at any time including mid-GRANT: state=IDLE, `gnt`=4'b0000, `x0`=0, `x1`=0, `busy`=0, `timeout`=0, ptr=0, own=0, hold counter=0.
  - After reset, index 0 has highest priority.

## Timing
- Request-to-grant latency: `req` sampled high at edge N while IDLE produces `gnt` high after edge N. The requester sees the grant in the cycle following N.
- Release latency: `req[own]` sampled low at edge M clears `gnt` after edge M. The earliest next grant appears after edge M+1.
- `busy` is registered with `gnt` and equals (`gnt` != 0).
- `x1`/`x0` change only on the same edge that asserts a new grant, so the decoder select is stable for the entire grant.
- If a request and release occur on the same edge, the release wins. The new request is arbitrated from IDLE at the next edge.

## Configuration
- Macro `ARB_TIMEOUT_EN` controls forced revocation.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter equals MAX_HOLD−1 and `req[own]` is still 1 at an edge: `gnt`←0, state←IDLE, `timeout`←1 for exactly one cycle.
  - ptr has already advanced past the revoked owner, so other requesters get priority.
  - The revoked requester may keep `req` high and re-enter arbitration normally.
- Undefined:
  - No counter is built.
  - Grants are unbounded.
  - `timeout` is tied to 0.

## Test plan
- Reset: hold `rst`=1 with `req`=4'b1111, then release. Expect `gnt`=0001, {`x1`,`x0`}=00 one edge after `rst` falls while `req` stays high. All outputs are 0 during reset.
- Rotation: keep `req`=4'b1111 and drop each owner's bit for one cycle after 3 GRANT cycles. Expect grant order 0,1,2,3,0 with {`x1`,`x0`}=00,01,10,11,00. Expect one IDLE cycle between each grant.
- Sparse priority: after a grant to 2, apply `req`=4'b0011. Expect the next grant to go to 0 (the scan starts at 3), then to 1.
- Hold and ignore: the owner is 1 and `req` goes from 0010 to 1110. Expect `gnt` to stay 0010 until `req[1]`=0. The next grant goes to 2.
- Async reset mid-grant: assert `rst` between edges during GRANT with owner 3. Expect `gnt`=0 immediately without waiting for an edge, and ptr=0 on restart.
- With `ARB_TIMEOUT_EN` and MAX_HOLD=4: `req`=4'b0001 is held high. Expect `gnt`=0001 for exactly 4 cycles, then a `timeout` pulse of 1 cycle with `gnt`=0. Expect a re-grant to 0 one edge later.
